// File: rtl/adder_share_arbiter_if.sv
// Request, adder and response signals of the shared-adder arbiter.
// Latency: none (wires only); the slave modport is the arbiter's view.
// Backpressure: carried by req*_ready_o and rsp_ready_i.
//
// Signals:
//   req0_*/req1_*  two valid/ready operand request ports
//   add_src*_o     operands to the external adder, add_sum_i its sum
//   rsp_*          one-entry response register with valid/ready
interface adder_share_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic              req0_ready_o;

    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic              req1_ready_o;

    logic [DATA_W-1:0] add_src1_o;
    logic [DATA_W-1:0] add_src2_o;
    logic [DATA_W-1:0] add_sum_i;

    logic              rsp_valid_o;
    logic              rsp_id_o;
    logic [DATA_W-1:0] rsp_sum_o;
    logic              rsp_ready_i;

    // Arbiter side.
    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i,
        output req0_ready_o,
        input  req1_valid_i, req1_a_i, req1_b_i,
        output req1_ready_o,
        output add_src1_o, add_src2_o,
        input  add_sum_i,
        output rsp_valid_o, rsp_id_o, rsp_sum_o,
        input  rsp_ready_i
    );

    // Requesters, adder and response consumer side.
    modport master (
        output req0_valid_i, req0_a_i, req0_b_i,
        input  req0_ready_o,
        output req1_valid_i, req1_a_i, req1_b_i,
        input  req1_ready_o,
        input  add_src1_o, add_src2_o,
        output add_sum_i,
        input  rsp_valid_o, rsp_id_o, rsp_sum_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one external adder between two requesters, result held in a 1-entry response register.
// Latency: 1 cycle from request accept to rsp_valid_o; back-to-back accepts with no bubble.
// Backpressure: while the response is held and rsp_ready_i is low, both request ready outputs stay low.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    adder_share_arbiter_if.slave (requests, adder operands/sum, response)
module adder_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    adder_share_arbiter_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic              last_gnt;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_sum;

    logic              gnt_vld;
    logic              gnt_id;
    logic              can_accept;
    logic              accept;

    // A held response may drain in the same cycle a new one is captured.
    assign can_accept = (state == EMPTY) || bus.rsp_ready_i;

    // On contention the port that did not win the last accept goes first.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            gnt_vld = 1'b1;
            gnt_id  = ~last_gnt;
        end else if (bus.req0_valid_i) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
        end else if (bus.req1_valid_i) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    assign accept = gnt_vld && can_accept && !rst_i;

    assign bus.req0_ready_o = accept && (gnt_id == 1'b0);
    assign bus.req1_ready_o = accept && (gnt_id == 1'b1);

    // Operands follow the grant even during a stall; the adder output is
    // simply not captured until can_accept.
    always_comb begin
        bus.add_src1_o = '0;
        bus.add_src2_o = '0;
        if (gnt_vld && !rst_i) begin
            if (gnt_id) begin
                bus.add_src1_o = bus.req1_a_i;
                bus.add_src2_o = bus.req1_b_i;
            end else begin
                bus.add_src1_o = bus.req0_a_i;
                bus.add_src2_o = bus.req0_b_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= EMPTY;
            last_gnt <= 1'b1;
            rsp_id   <= 1'b0;
            rsp_sum  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= FULL;
                        rsp_sum  <= bus.add_sum_i;
                        rsp_id   <= gnt_id;
                        last_gnt <= gnt_id;
                    end
                end
                FULL: begin
                    if (accept) begin
                        rsp_sum  <= bus.add_sum_i;
                        rsp_id   <= gnt_id;
                        last_gnt <= gnt_id;
                    end else if (bus.rsp_ready_i) begin
                        // Drain only: payload fields keep their last value.
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.rsp_valid_o = (state == FULL);
    assign bus.rsp_id_o    = rsp_id;
    assign bus.rsp_sum_o   = rsp_sum;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural adder attached.
// Expected responses are queued at issue and popped by a monitor on each response handshake.
module tb_adder_share_arbiter;

    localparam int DATA_W = 32;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [DATA_W:0] exp_q[$];   // {id, sum}

    adder_share_arbiter_if #(.DATA_W(DATA_W)) bus ();

    adder_share_arbiter #(.DATA_W(DATA_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // The shared adder: 32-bit wrap-around sum.
    assign bus.add_sum_i = bus.add_src1_o + bus.add_src2_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares each response as it is consumed.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid_o === 1'b1 && bus.rsp_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d sum=0x%08h expected none",
                         bus.rsp_id_o, bus.rsp_sum_o);
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, bus.rsp_id_o}, {31'd0, e[DATA_W]});
                chk("rsp_sum", bus.rsp_sum_o, e[DATA_W-1:0]);
            end
        end
    end

    logic [DATA_W-1:0] p0_a [3] = '{32'd1,   32'd10,   32'd0};
    logic [DATA_W-1:0] p0_b [3] = '{32'd2,   32'd20,   32'd0};
    logic [DATA_W-1:0] p1_a [3] = '{32'd100, 32'd1000, 32'd0};
    logic [DATA_W-1:0] p1_b [3] = '{32'd200, 32'd2000, 32'd0};
    logic [DATA_W-1:0] p0_s [2] = '{32'd3,   32'd30};
    logic [DATA_W-1:0] p1_s [2] = '{32'd300, 32'd3000};

    initial begin
        int i0;
        int i1;
        rst = 1'b1;
        bus.req0_valid_i = 1'b1;   // held high to show reset masks ready
        bus.req0_a_i     = 32'd5;
        bus.req0_b_i     = 32'd6;
        bus.req1_valid_i = 1'b0;
        bus.req1_a_i     = '0;
        bus.req1_b_i     = '0;
        bus.rsp_ready_i  = 1'b1;

        // 1. Reset for two cycles
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
            chk("rst_rsp_sum", bus.rsp_sum_o, 32'd0);
            chk("rst_ready0", {31'd0, bus.req0_ready_o}, 32'd0);
            chk("rst_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
            chk("rst_src1", bus.add_src1_o, 32'd0);
            chk("rst_src2", bus.add_src2_o, 32'd0);
            tick();
        end
        rst = 1'b0;

        // 2. Single request on port 0
        bus.req0_a_i = 32'd4;
        bus.req0_b_i = 32'h0040_0000;
        @(negedge clk);
        chk("p0_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
        chk("p0_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
        chk("p0_src1", bus.add_src1_o, 32'd4);
        chk("p0_src2", bus.add_src2_o, 32'h0040_0000);
        exp_q.push_back({1'b0, 32'h0040_0004});
        tick();
        bus.req0_valid_i = 1'b0;
        // Port 1 alone, so the next tie starts with port 0.
        bus.req1_valid_i = 1'b1;
        bus.req1_a_i     = 32'h100;
        bus.req1_b_i     = 32'h20;
        @(negedge clk);
        chk("p0_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
        chk("p0_rsp_id", {31'd0, bus.rsp_id_o}, 32'd0);
        chk("p0_rsp_sum", bus.rsp_sum_o, 32'h0040_0004);
        chk("p1_ready1", {31'd0, bus.req1_ready_o}, 32'd1);
        exp_q.push_back({1'b1, 32'h120});
        tick();

        // 3. Contention: grants 0,1,0,1 with no bubbles
        i0 = 0;
        i1 = 0;
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req0_a_i = p0_a[i0];
            bus.req0_b_i = p0_b[i0];
            bus.req1_a_i = p1_a[i1];
            bus.req1_b_i = p1_b[i1];
            @(negedge clk);
            chk("rr_ready0", {31'd0, bus.req0_ready_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, bus.req1_ready_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
            if (k % 2 == 0) begin
                exp_q.push_back({1'b0, p0_s[i0]});
                i0++;
            end else begin
                exp_q.push_back({1'b1, p1_s[i1]});
                i1++;
            end
            tick();
        end

        // 4. Wrap-around sums
        bus.req1_valid_i = 1'b0;
        bus.req0_a_i = 32'hFFFF_FFFF;
        bus.req0_b_i = 32'd2;
        @(negedge clk);
        chk("wrap1_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
        exp_q.push_back({1'b0, 32'h0000_0001});
        tick();
        bus.req0_a_i = 32'h8000_0000;
        bus.req0_b_i = 32'h8000_0000;
        @(negedge clk);
        chk("wrap2_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
        exp_q.push_back({1'b0, 32'h0000_0000});
        tick();

        // 5. Stall with both requests pending (last grant was port 0)
        bus.rsp_ready_i  = 1'b0;
        bus.req0_a_i     = 32'd7;
        bus.req0_b_i     = 32'd8;
        bus.req1_valid_i = 1'b1;
        bus.req1_a_i     = 32'h11;
        bus.req1_b_i     = 32'h22;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_ready0", {31'd0, bus.req0_ready_o}, 32'd0);
            chk("stall_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
            chk("stall_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
            chk("stall_rsp_id", {31'd0, bus.rsp_id_o}, 32'd0);
            chk("stall_rsp_sum", bus.rsp_sum_o, 32'd0);
            tick();
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready1", {31'd0, bus.req1_ready_o}, 32'd1);
        chk("release_ready0", {31'd0, bus.req0_ready_o}, 32'd0);
        exp_q.push_back({1'b1, 32'h33});
        tick();
        bus.req1_valid_i = 1'b0;
        @(negedge clk);
        chk("after_release_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
        exp_q.push_back({1'b0, 32'd15});
        tick();

        // 6. Reset while a response is held: the response is discarded
        bus.rsp_ready_i  = 1'b0;
        bus.req1_valid_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready0", {31'd0, bus.req0_ready_o}, 32'd0);
        chk("midrst_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
        chk("midrst_src1", bus.add_src1_o, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        bus.rsp_ready_i = 1'b1;
        bus.req0_a_i = 32'd3;
        bus.req0_b_i = 32'd4;
        bus.req1_a_i = 32'd5;
        bus.req1_b_i = 32'd6;
        @(negedge clk);
        chk("postrst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("postrst_rsp_sum", bus.rsp_sum_o, 32'd0);
        chk("postrst_tie_ready0", {31'd0, bus.req0_ready_o}, 32'd1);
        chk("postrst_tie_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
        exp_q.push_back({1'b0, 32'd7});
        tick();
        bus.req0_valid_i = 1'b0;
        @(negedge clk);
        chk("postrst_ready1", {31'd0, bus.req1_ready_o}, 32'd1);
        exp_q.push_back({1'b1, 32'd11});
        tick();
        bus.req1_valid_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("idle_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
